// File: rtl/mem_arbiter.sv
// Round-robin line-fill arbiter between I-cache and D-cache over one single-ported memory array.
// Latency from request sample to valid pulse is LAT+2 cycles (LAT+3 with writeback); requests are level-held, so busy acts as backpressure.
module mem_arbiter #(
  parameter int WORD_W     = 16,
  parameter int LINE_WORDS = 4,
  parameter int LAT        = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_req,
  input  logic [15:0]                  i_addr,
  output logic                         i_valid,
  output logic [WORD_W*LINE_WORDS-1:0] i_rdata,
  input  logic                         d_req,
  input  logic [15:0]                  d_addr,
  input  logic                         d_evict,
  input  logic [15:0]                  d_evict_addr,
  input  logic [WORD_W*LINE_WORDS-1:0] d_evict_data,
  output logic                         d_valid,
  output logic [WORD_W*LINE_WORDS-1:0] d_rdata,
  output logic                         mem_re,
  output logic                         mem_we,
  output logic [15:0]                  mem_addr,
  output logic [WORD_W*LINE_WORDS-1:0] mem_wdata,
  input  logic [WORD_W*LINE_WORDS-1:0] mem_rdata,
  output logic                         busy
);

  localparam int LINE_W = WORD_W * LINE_WORDS;

  typedef enum logic [2:0] {IDLE, WB, WAIT, READ, RESP} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                gnt_d;
  logic                last_d;
  logic                mask_i, mask_d;
  logic [15:0]         fill_addr;
  logic [15:0]         ev_addr;
  logic [LINE_W-1:0]   ev_data;
  logic                elig_i, elig_d, pick_d;

  // On a tie the port opposite the last one served wins.
  assign elig_i = i_req & ~mask_i;
  assign elig_d = d_req & ~mask_d;
  assign pick_d = elig_d & (~elig_i | ~last_d);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (elig_i | elig_d) begin
          cnt_nxt   = 4'(LAT);
          state_nxt = (pick_d & d_evict) ? WB : WAIT;
        end
      end
      WB:   state_nxt = WAIT;
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = READ;
      end
      READ: state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = (state == WB);
    mem_re    = (state == READ);
    mem_wdata = ev_data;
    busy      = (state != IDLE);
    mem_addr  = 16'h0000;
    if (state == WB)        mem_addr = ev_addr & 16'hFFFC;
    else if (state == READ) mem_addr = fill_addr & 16'hFFFC;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      gnt_d     <= 1'b0;
      last_d    <= 1'b1;
      mask_i    <= 1'b0;
      mask_d    <= 1'b0;
      fill_addr <= 16'h0000;
      ev_addr   <= 16'h0000;
      ev_data   <= '0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          // The served port is blocked for exactly one IDLE cycle.
          mask_i <= 1'b0;
          mask_d <= 1'b0;
          if (elig_i | elig_d) begin
            gnt_d     <= pick_d;
            fill_addr <= pick_d ? d_addr : i_addr;
            if (pick_d) begin
              ev_addr <= d_evict_addr;
              ev_data <= d_evict_data;
            end
          end
        end
        READ: begin
          if (gnt_d) begin
            d_rdata <= mem_rdata;
            d_valid <= 1'b1;
          end else begin
            i_rdata <= mem_rdata;
            i_valid <= 1'b1;
          end
        end
        RESP: begin
          last_d <= gnt_d;
          mask_i <= ~gnt_d;
          mask_d <= gnt_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: timeline model of grants/latency checked every cycle, plus directed literal checks.
// A second instance with LAT=1 is held in reset except during the short-latency phase.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n, sel1;
  logic        i_req, d_req, d_evict;
  logic [15:0] i_addr, d_addr, d_evict_addr;
  logic [63:0] d_evict_data, mem_rdata;

  logic        i_valid0, d_valid0, mem_re0, mem_we0, busy0;
  logic [63:0] i_rdata0, d_rdata0, mem_wdata0;
  logic [15:0] mem_addr0;
  logic        i_valid1, d_valid1, mem_re1, mem_we1, busy1;
  logic [63:0] i_rdata1, d_rdata1, mem_wdata1;
  logic [15:0] mem_addr1;

  mem_arbiter #(.WORD_W(16), .LINE_WORDS(4), .LAT(4)) u_dut0 (
    .clk(clk), .reset_n(rst0_n),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid0), .i_rdata(i_rdata0),
    .d_req(d_req), .d_addr(d_addr), .d_evict(d_evict), .d_evict_addr(d_evict_addr),
    .d_evict_data(d_evict_data), .d_valid(d_valid0), .d_rdata(d_rdata0),
    .mem_re(mem_re0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata), .busy(busy0)
  );

  mem_arbiter #(.WORD_W(16), .LINE_WORDS(4), .LAT(1)) u_dut1 (
    .clk(clk), .reset_n(rst1_n),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_addr(d_addr), .d_evict(d_evict), .d_evict_addr(d_evict_addr),
    .d_evict_data(d_evict_data), .d_valid(d_valid1), .d_rdata(d_rdata1),
    .mem_re(mem_re1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata), .busy(busy1)
  );

  // Observed outputs of whichever instance is active; the idle one sits in reset with zero outputs.
  logic        obs_iv, obs_dv, obs_re, obs_we, obs_busy;
  logic [63:0] obs_irdata, obs_drdata, obs_wdata;
  logic [15:0] obs_addr, mem_addr_any;
  assign obs_iv     = sel1 ? i_valid1   : i_valid0;
  assign obs_dv     = sel1 ? d_valid1   : d_valid0;
  assign obs_re     = sel1 ? mem_re1    : mem_re0;
  assign obs_we     = sel1 ? mem_we1    : mem_we0;
  assign obs_busy   = sel1 ? busy1      : busy0;
  assign obs_irdata = sel1 ? i_rdata1   : i_rdata0;
  assign obs_drdata = sel1 ? d_rdata1   : d_rdata0;
  assign obs_wdata  = sel1 ? mem_wdata1 : mem_wdata0;
  assign obs_addr   = sel1 ? mem_addr1  : mem_addr0;
  assign mem_addr_any = mem_addr0 | mem_addr1;

  // Main memory: word at address w holds w + 0x1000.
  logic [63:0] mem [0:16383];
  assign mem_rdata = (mem_re0 | mem_re1) ? mem[mem_addr_any[15:2]] : 64'h0;
  always @(posedge clk)
    if (mem_we0 | mem_we1) mem[mem_addr_any[15:2]] = mem_we0 ? mem_wdata0 : mem_wdata1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: one transaction occupies cycles t0 .. t0+evict+lat+1; the cycle after is the first idle one.
  logic        m_act = 1'b0, m_port = 1'b0, m_e = 1'b0, m_last = 1'b1, m_mvld = 1'b0, m_mport = 1'b0;
  int          m_t0 = 0, m_end = 0, m_mcyc = 0, m_lat = 4;
  logic [15:0] m_fill = 16'h0, m_ev = 16'h0;
  logic [63:0] m_evd = 64'h0, m_exp = 64'h0, e_i = 64'h0, e_d = 64'h0;

  always @(negedge clk) begin : model
    logic        mrst, bz, we, re, iv, dv, ei, ed, pd;
    logic [15:0] ad;
    int          c, rdc;
    mrst = sel1 ? rst1_n : rst0_n;
    c    = cyc;
    if (!mrst) begin
      m_act = 1'b0; m_last = 1'b1; m_mvld = 1'b0; e_i = 64'h0; e_d = 64'h0;
    end
    bz  = m_act && c >= m_t0 && c < m_end;
    rdc = m_t0 + (m_e ? 1 : 0) + m_lat;
    we  = bz && m_e && c == m_t0;
    re  = bz && c == rdc;
    iv  = bz && c == rdc + 1 && !m_port;
    dv  = bz && c == rdc + 1 && m_port;
    ad  = we ? (m_ev & 16'hFFFC) : re ? (m_fill & 16'hFFFC) : 16'h0;
    if (iv) e_i = m_exp;
    if (dv) e_d = m_exp;
    chk("busy",     64'(obs_busy),   64'(bz));
    chk("mem_we",   64'(obs_we),     64'(we));
    chk("mem_re",   64'(obs_re),     64'(re));
    chk("mem_addr", 64'(obs_addr),   64'(ad));
    chk("i_valid",  64'(obs_iv),     64'(iv));
    chk("d_valid",  64'(obs_dv),     64'(dv));
    chk("i_rdata",  obs_irdata,      e_i);
    chk("d_rdata",  obs_drdata,      e_d);
    chk("re_we_excl", 64'(obs_re & obs_we), 64'h0);
    if (we) chk("mem_wdata", obs_wdata, m_evd);
    if (mrst && !bz) begin
      if (m_act) begin
        m_act = 1'b0; m_last = m_port; m_mvld = 1'b1; m_mport = m_port; m_mcyc = c;
      end
      ei = i_req && !(m_mvld && !m_mport && c == m_mcyc);
      ed = d_req && !(m_mvld &&  m_mport && c == m_mcyc);
      if (ei || ed) begin
        pd     = ed && (!ei || !m_last);
        m_act  = 1'b1;
        m_port = pd;
        m_t0   = c + 1;
        m_lat  = sel1 ? 1 : 4;
        m_e    = pd && d_evict;
        m_fill = pd ? d_addr : i_addr;
        m_ev   = d_evict_addr;
        m_evd  = d_evict_data;
        m_end  = m_t0 + (m_e ? 1 : 0) + m_lat + 2;
        m_exp  = (m_e && m_ev[15:2] == m_fill[15:2]) ? m_evd : mem[m_fill[15:2]];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // n = cycle number of the valid pulse counted from the first edge that samples the request.
  task automatic wait_pulse(input logic dport, input int max, output int n, output int wn,
                            output logic [15:0] wa);
    n = -1; wn = -1; wa = 16'h0;
    for (int k = 1; k <= max; k++) begin
      @(posedge clk);
      #1;
      if (obs_we && wn < 0) begin wn = k; wa = obs_addr; end
      if (dport ? obs_dv : obs_iv) begin n = k; break; end
    end
  endtask

  int          n, wn, lat0, lat1;
  logic [15:0] wa;
  int          seq [4];

  initial begin
    for (int k = 0; k < 16384; k++)
      mem[k] = {16'(4*k + 3 + 4096), 16'(4*k + 2 + 4096), 16'(4*k + 1 + 4096), 16'(4*k + 4096)};
    i_req = 0; d_req = 0; d_evict = 0;
    i_addr = 0; d_addr = 0; d_evict_addr = 0; d_evict_data = 0;
    sel1 = 0; rst0_n = 0; rst1_n = 0;
    repeat (3) tick;
    chk("rst_busy",   64'(obs_busy), 64'h0);
    chk("rst_irdata", obs_irdata,    64'h0);
    chk("rst_addr",   64'(obs_addr), 64'h0);
    rst0_n = 1;
    tick;

    // Plain I fill
    i_req = 1; i_addr = 16'h0025;
    wait_pulse(1'b0, 20, n, wn, wa);
    i_req = 0;
    chk("t1_lat",   64'(n), 64'd6);
    chk("t1_rdata", obs_irdata, 64'h1027_1026_1025_1024);
    tick;

    // D fill with same-line writeback
    d_req = 1; d_evict = 1; d_evict_addr = 16'h0040; d_evict_data = 64'h4444_3333_2222_1111;
    d_addr = 16'h0040;
    wait_pulse(1'b1, 20, n, wn, wa);
    d_req = 0; d_evict = 0;
    chk("t2_lat",     64'(n),  64'd7);
    chk("t2_wb_cyc",  64'(wn), 64'd1);
    chk("t2_wb_addr", 64'(wa), 64'h40);
    chk("t2_rdata",   obs_drdata, 64'h4444_3333_2222_1111);
    tick;

    // Simultaneous requests after reset, both held: I, D, I, D
    rst0_n = 0; tick; rst0_n = 1; tick;
    i_req = 1; d_req = 1; i_addr = 16'h0100; d_addr = 16'h0080;
    lat0 = -1; lat1 = -1;
    for (int j = 0; j < 4; j++) begin
      seq[j] = -1;
      for (int k = 1; k <= 20; k++) begin
        tick;
        if (obs_iv) begin seq[j] = 0; n = k; break; end
        if (obs_dv) begin seq[j] = 1; n = k; break; end
      end
      if (j == 0) lat0 = n;
      if (j == 1) lat1 = n;
    end
    i_req = 0; d_req = 0;
    for (int j = 0; j < 4; j++) chk($sformatf("t3_order%0d", j), 64'(seq[j]), 64'(j % 2));
    chk("t3_lat_first",  64'(lat0), 64'd6);
    chk("t3_lat_second", 64'(lat1), 64'd7);
    tick;

    // Reset during WAIT of a D fill, then the held request completes normally
    d_req = 1; d_addr = 16'h00C0;
    repeat (4) tick;
    rst0_n = 0;
    #1;
    chk("t4_busy", 64'(obs_busy), 64'h0);
    chk("t4_dv",   64'(obs_dv),   64'h0);
    tick; tick;
    rst0_n = 1;
    wait_pulse(1'b1, 20, n, wn, wa);
    d_req = 0;
    chk("t4_lat",   64'(n), 64'd6);
    chk("t4_rdata", obs_drdata, 64'h10C3_10C2_10C1_10C0);
    tick;

    // I held one extra cycle after its valid: no duplicate grant
    i_req = 1; i_addr = 16'h0200;
    wait_pulse(1'b0, 20, n, wn, wa);
    tick; tick;
    i_req = 0;
    repeat (4) tick;
    chk("t5_no_dup", 64'(obs_busy), 64'h0);

    // Same with D waiting: D is granted in the first idle cycle
    i_req = 1; i_addr = 16'h0210;
    wait_pulse(1'b0, 20, n, wn, wa);
    d_req = 1; d_addr = 16'h0240;
    tick; tick;
    i_req = 0;
    wait_pulse(1'b1, 20, n, wn, wa);
    d_req = 0;
    chk("t5_dlat",  64'(n), 64'd5);
    chk("t5_rdata", obs_drdata, 64'h1243_1242_1241_1240);
    tick;

    // LAT=1 instance
    rst0_n = 0; sel1 = 1; tick;
    rst1_n = 1; tick;
    i_req = 1; i_addr = 16'h0300;
    wait_pulse(1'b0, 20, n, wn, wa);
    i_req = 0;
    chk("t6_ilat",  64'(n), 64'd3);
    chk("t6_irdata", obs_irdata, 64'h1303_1302_1301_1300);
    tick;
    d_req = 1; d_evict = 1; d_evict_addr = 16'h0382; d_evict_data = 64'hDEAD_BEEF_0123_4567;
    d_addr = 16'h0346;
    wait_pulse(1'b1, 20, n, wn, wa);
    d_req = 0; d_evict = 0;
    chk("t6_dlat",    64'(n),  64'd4);
    chk("t6_wb_cyc",  64'(wn), 64'd1);
    chk("t6_wb_addr", 64'(wa), 64'h0380);
    chk("t6_drdata",  obs_drdata, 64'h1347_1346_1345_1344);
    tick;
    chk("t6_wb_mem",  mem[16'h0380 >> 2], 64'hDEAD_BEEF_0123_4567);
    repeat (3) tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port block-memory arbiter and sequencer between the instruction cache, the data cache and a single-ported line-wide main memory array. It accepts line-fill requests from both caches and performs an optional dirty-line writeback for the data cache. It grants one requester at a time by round-robin and models main-memory access latency with a wait counter. Memory-side traffic is serialized, so the array never sees two operations in one cycle.

## Interface
Parameters:
- WORD_W, 16, word width in bits
- LINE_WORDS, 4, words per cache line (line = 64 bits)
- LAT, 4, memory wait cycles per fill (1..15)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- i_req  in  1  I-cache fill request, level, held until i_valid seen
- i_addr  in  16  I-cache miss address; bits [1:0] ignored
- i_valid  out  1  one-cycle pulse, i_rdata holds the requested line
- i_rdata  out  64  filled line, word 0 in [15:0]
- d_req  in  1  D-cache fill request, level, held until d_valid seen
- d_addr  in  16  D-cache miss address; bits [1:0] ignored
- d_evict  in  1  dirty victim must be written back before the fill
- d_evict_addr  in  16  victim line address; bits [1:0] ignored
- d_evict_data  in  64  victim line data
- d_valid  out  1  one-cycle pulse, d_rdata holds the requested line
- d_rdata  out  64  filled line
- mem_re  out  1  line read strobe
- mem_we  out  1  line write strobe
- mem_addr  out  16  line address, bits [1:0] always 0
- mem_wdata  out  64  line write data
- mem_rdata  in  64  combinational read data for mem_addr while mem_re=1
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, WB, WAIT, READ, RESP.
- IDLE: if an eligible request is present, grant it. Latch the port id, the fill address and, for D, d_evict/d_evict_addr/d_evict_data. Load the counter with LAT. Next state is WB if the D port is granted with d_evict=1, else WAIT.
- WB: mem_we=1 with mem_addr={d_evict_addr[15:2],2'b00} and mem_wdata=d_evict_data for exactly one cycle, then WAIT.
- WAIT: decrement the counter each cycle. Leave for READ on the cycle the counter reads 1, so WAIT lasts exactly LAT cycles.
- READ: mem_re=1 with mem_addr={addr[15:2],2'b00}. At the closing edge, capture mem_rdata into the granted port's rdata register and set that port's valid. Then RESP.
- RESP: the granted port's valid is high for this one cycle. Update last_grant to the served port, mask the served port for the next IDLE cycle, then IDLE.
- Arbitration: a single eligible requester wins. If both are eligible, the port opposite last_grant wins. last_grant resets to D, so I wins the first tie.
- Masked port: its req is ignored in the first IDLE cycle after its RESP. The requester drops req in that cycle.
- Outside WB, mem_we=0, and mem_wdata is don't-care. Outside READ, mem_re=0. mem_re and mem_we are never high together.
- rdata registers hold their value until the next fill of the same port.
- If the victim line equals the fill line, WB precedes READ, so the fill returns the written-back data.
- Request inputs are not re-sampled after grant. Changes to req or addresses during a transaction are ignored.

## Timing
- Reset (async assert, any state): state=IDLE, counter=0, last_grant=D, mask cleared. i_valid=d_valid=0, i_rdata=d_rdata=0, mem_re=mem_we=0, mem_addr=0, busy=0. Any in-flight transaction is dropped with no valid pulse; a WB cut mid-cycle may be lost. Deassertion is used synchronously at the next edge.
- Latency, counted from the edge that samples req in IDLE (edge 0):
  - no evict: WAIT in cycles 1..LAT, READ in cycle LAT+1, valid in cycle LAT+2 (6 for LAT=4).
  - with evict: WB in cycle 1, valid in cycle LAT+3.
- Throughput: one transaction at a time; the next grant is sampled at the earliest in the cycle after RESP.

## Test plan
- Reset then i_req=1, i_addr=0x0025, LAT=4: mem_re one cycle with mem_addr=0x0024; i_valid pulses in cycle 6; i_rdata = words 0x24..0x27 from the memory model.
- d_req=1, d_evict=1, d_evict_addr=0x0040, d_evict_data=0x4444_3333_2222_1111, d_addr=0x0040: mem_we in cycle 1 at 0x0040; d_valid in cycle 7; d_rdata=0x4444_3333_2222_1111.
- i_req and d_req rise in the same cycle after reset: I is served first, D second. Alternation continues when both are held high, with no port served twice in a row.
- Assert reset_n=0 during WAIT of a D fill: all outputs go to 0 immediately, with no d_valid. After release, the same request completes with normal latency.
- i_req held high one extra cycle after i_valid, with d_req also high: the mask blocks a duplicate I grant and D is granted next.
- LAT=1 sweep: valid in cycle 3 without evict and cycle 4 with evict; mem_re and mem_we are never both high.
